// File: rtl/ecc_result_collector_if.sv
// Bundle between the ECC top / host side and the result collector:
// capture inputs, the result stream and the statistics block.
interface ecc_result_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                         done_in;
    logic [DATA_WIDTH-1:0]        data_in;
    logic [1:0]                   nerr_in;
    logic [1:0]                   mode_in;

    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [1:0]                   out_nerr;
    logic [1:0]                   out_mode;
    logic [15:0]                  out_tstamp;
    logic [$clog2(DEPTH):0]       fifo_count;

    logic                         clear_stats;
    logic [CNT_WIDTH-1:0]         ops_cnt;
    logic [CNT_WIDTH-1:0]         corr_cnt;
    logic [CNT_WIDTH-1:0]         uncorr_cnt;
    logic [CNT_WIDTH-1:0]         drop_cnt;
    logic                         overflow;

    modport master (
        output done_in, data_in, nerr_in, mode_in, out_ready, clear_stats,
        input  out_valid, out_data, out_nerr, out_mode, out_tstamp, fifo_count,
        input  ops_cnt, corr_cnt, uncorr_cnt, drop_cnt, overflow
    );

    modport slave (
        input  done_in, data_in, nerr_in, mode_in, out_ready, clear_stats,
        output out_valid, out_data, out_nerr, out_mode, out_tstamp, fifo_count,
        output ops_cnt, corr_cnt, uncorr_cnt, drop_cnt, overflow
    );
endinterface

// File: rtl/ecc_result_collector.sv
// Captures each completed ECC operation into a small FIFO with saturating statistics.
// Define ECC_COLLECT_TIMESTAMP_EN to store a 16-bit capture timestamp per entry.
module ecc_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    ecc_result_collector_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [CNT_WIDTH-1:0] stat_t;

    logic                  done_q;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] headData_q;
    logic [1:0]            headNerr_q, headMode_q;
    stat_t                 opsCnt_q, corrCnt_q, uncorrCnt_q, dropCnt_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] memData [DEPTH];
    logic [1:0]            memNerr [DEPTH];
    logic [1:0]            memMode [DEPTH];

    logic captureEvt, full, pop, push, drop, headFromInput;

    function automatic stat_t satInc(stat_t v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        captureEvt    = bus.done_in & ~done_q;
        full          = (count_q == CNT_W'(DEPTH));
        pop           = valid_q & bus.out_ready;
        push          = captureEvt & (~full | pop);
        drop          = captureEvt & full & ~pop;
        wrPtr_d       = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d       = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        // The new entry becomes the head when nothing else remains after this pop.
        headFromInput = push & (count_q == CNT_W'(pop));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memData[wrPtr_q] <= bus.data_in;
            memNerr[wrPtr_q] <= bus.nerr_in;
            memMode[wrPtr_q] <= bus.mode_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q     <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            headData_q <= '0;
            headNerr_q <= '0;
            headMode_q <= '0;
        end else begin
            done_q  <= bus.done_in;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            if (count_d != '0) begin
                if (headFromInput) begin
                    headData_q <= bus.data_in;
                    headNerr_q <= bus.nerr_in;
                    headMode_q <= bus.mode_in;
                end else begin
                    headData_q <= memData[rdPtr_d];
                    headNerr_q <= memNerr[rdPtr_d];
                    headMode_q <= memMode[rdPtr_d];
                end
            end
        end
    end

    // Clear wins over a same-cycle event, whose statistics are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opsCnt_q    <= '0;
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
            dropCnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (bus.clear_stats) begin
            opsCnt_q    <= '0;
            corrCnt_q   <= '0;
            uncorrCnt_q <= '0;
            dropCnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (captureEvt) begin
            opsCnt_q <= satInc(opsCnt_q);
            if (bus.nerr_in == 2'b01) begin
                corrCnt_q <= satInc(corrCnt_q);
            end
            if (bus.nerr_in[1]) begin
                uncorrCnt_q <= satInc(uncorrCnt_q);
            end
            if (drop) begin
                dropCnt_q  <= satInc(dropCnt_q);
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef ECC_COLLECT_TIMESTAMP_EN
    logic [15:0] tstamp_q;
    logic [15:0] headTs_q;
    logic [15:0] memTs [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            memTs[wrPtr_q] <= tstamp_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tstamp_q <= '0;
            headTs_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 16'd1;
            if (count_d != '0) begin
                headTs_q <= headFromInput ? tstamp_q : memTs[rdPtr_d];
            end
        end
    end

    assign bus.out_tstamp = headTs_q;
`else
    assign bus.out_tstamp = '0;
`endif

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = headData_q;
    assign bus.out_nerr   = headNerr_q;
    assign bus.out_mode   = headMode_q;
    assign bus.fifo_count = count_q;
    assign bus.ops_cnt    = opsCnt_q;
    assign bus.corr_cnt   = corrCnt_q;
    assign bus.uncorr_cnt = uncorrCnt_q;
    assign bus.drop_cnt   = dropCnt_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ecc_result_collector.sv
// Directed self-checking bench for ecc_result_collector.
// Counters are built 8 bits wide here so saturation is reachable in a short run.
module tb_ecc_result_collector;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nAssert = 0;
    int   nFail   = 0;

    logic [15:0] t1, t2;

    ecc_result_collector_if #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) bus ();

    ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic done, input logic [31:0] data,
                                 input logic [1:0] nerr, input logic [1:0] mode);
        bus.done_in = done;
        bus.data_in = data;
        bus.nerr_in = nerr;
        bus.mode_in = mode;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge of done_in, then one idle cycle.
    task automatic pulseEvent(input logic [31:0] data, input logic [1:0] nerr, input logic [1:0] mode);
        applyStimulus(1'b1, data, nerr, mode);
        cycle();
        bus.done_in = 1'b0;
        cycle();
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 2'b00, 2'b00);
        bus.out_ready   = 1'b0;
        bus.clear_stats = 1'b0;
        repeat (3) cycle();

        checkOutput("rst_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_count", 32'(bus.fifo_count), 32'h0);
        checkOutput("rst_data", bus.out_data, 32'h0);
        checkOutput("rst_ops", 32'(bus.ops_cnt), 32'h0);
        checkOutput("rst_ovf", 32'(bus.overflow), 32'h0);
        checkOutput("rst_tstamp", 32'(bus.out_tstamp), 32'h0);
        rst = 1'b1;
        cycle();

        $display("[TB] single pulse capture");
        applyStimulus(1'b1, 32'h0000_00A5, 2'b00, 2'b00);
        cycle();
        bus.done_in = 1'b0;
        checkOutput("t1_valid", 32'(bus.out_valid), 32'h1);
        checkOutput("t1_data", bus.out_data, 32'hA5);
        checkOutput("t1_ops", 32'(bus.ops_cnt), 32'h1);
        checkOutput("t1_corr", 32'(bus.corr_cnt), 32'h0);
        checkOutput("t1_count", 32'(bus.fifo_count), 32'h1);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        checkOutput("t1_valid_after_pop", 32'(bus.out_valid), 32'h0);
        checkOutput("t1_data_hold", bus.out_data, 32'hA5);

        $display("[TB] held done_in captures once");
        applyStimulus(1'b1, 32'h1111_2222, 2'b01, 2'b01);
        repeat (5) cycle();
        bus.done_in = 1'b0;
        cycle();
        checkOutput("t2_count", 32'(bus.fifo_count), 32'h1);
        checkOutput("t2_corr", 32'(bus.corr_cnt), 32'h1);
        checkOutput("t2_ops", 32'(bus.ops_cnt), 32'h2);
        checkOutput("t2_data", bus.out_data, 32'h1111_2222);
        checkOutput("t2_nerr", 32'(bus.out_nerr), 32'h1);
        checkOutput("t2_mode", 32'(bus.out_mode), 32'h1);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        $display("[TB] overflow on full FIFO");
        for (int i = 1; i <= 5; i++) pulseEvent(32'(i), 2'b00, 2'b10);
        checkOutput("t3_count", 32'(bus.fifo_count), 32'h4);
        checkOutput("t3_drop", 32'(bus.drop_cnt), 32'h1);
        checkOutput("t3_ovf", 32'(bus.overflow), 32'h1);
        checkOutput("t3_ops", 32'(bus.ops_cnt), 32'h7);
        checkOutput("t3_head_stable", bus.out_data, 32'h1);
        checkOutput("t3_mode", 32'(bus.out_mode), 32'h2);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t3_pop_valid", 32'(bus.out_valid), 32'h1);
            checkOutput("t3_pop_data", bus.out_data, 32'(k));
            cycle();
        end
        bus.out_ready = 1'b0;
        checkOutput("t3_empty_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("t3_empty_count", 32'(bus.fifo_count), 32'h0);

        $display("[TB] push and pop together on full FIFO");
        for (int i = 0; i < 4; i++) pulseEvent(32'h10 + 32'(i), 2'b00, 2'b00);
        checkOutput("t4_full", 32'(bus.fifo_count), 32'h4);
        applyStimulus(1'b1, 32'h14, 2'b00, 2'b00);
        bus.out_ready = 1'b1;
        cycle();
        bus.done_in   = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("t4_count", 32'(bus.fifo_count), 32'h4);
        checkOutput("t4_drop", 32'(bus.drop_cnt), 32'h1);
        checkOutput("t4_head", bus.out_data, 32'h11);
        checkOutput("t4_ops", 32'(bus.ops_cnt), 32'd12);
        cycle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t4_pop_data", bus.out_data, 32'h11 + 32'(k));
            cycle();
        end
        bus.out_ready = 1'b0;
        checkOutput("t4_empty", 32'(bus.out_valid), 32'h0);

        $display("[TB] uncorrectable count and saturation");
        pulseEvent(32'h33, 2'b11, 2'b01);
        checkOutput("t5_uncorr11", 32'(bus.uncorr_cnt), 32'h1);
        checkOutput("t5_corr_untouched", 32'(bus.corr_cnt), 32'h1);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) pulseEvent(32'h100 + 32'(i), 2'b10, 2'b10);
        checkOutput("t5_uncorr_sat", 32'(bus.uncorr_cnt), 32'hFF);
        checkOutput("t5_ops_sat", 32'(bus.ops_cnt), 32'hFF);
        checkOutput("t5_drop_sat", 32'(bus.drop_cnt), 32'hFF);
        checkOutput("t5_corr", 32'(bus.corr_cnt), 32'h1);
        checkOutput("t5_count", 32'(bus.fifo_count), 32'h4);

        applyStimulus(1'b1, 32'hDEAD, 2'b01, 2'b00);
        bus.clear_stats = 1'b1;
        cycle();
        bus.done_in     = 1'b0;
        bus.clear_stats = 1'b0;
        checkOutput("t5_clr_ops", 32'(bus.ops_cnt), 32'h0);
        checkOutput("t5_clr_corr", 32'(bus.corr_cnt), 32'h0);
        checkOutput("t5_clr_uncorr", 32'(bus.uncorr_cnt), 32'h0);
        checkOutput("t5_clr_drop", 32'(bus.drop_cnt), 32'h0);
        checkOutput("t5_clr_ovf", 32'(bus.overflow), 32'h0);
        checkOutput("t5_clr_count", 32'(bus.fifo_count), 32'h4);
        checkOutput("t5_clr_head", bus.out_data, 32'h100);
        checkOutput("t5_clr_nerr", 32'(bus.out_nerr), 32'h2);
        cycle();
        pulseEvent(32'hBEEF, 2'b01, 2'b00);
        checkOutput("t5_post_ops", 32'(bus.ops_cnt), 32'h1);
        checkOutput("t5_post_corr", 32'(bus.corr_cnt), 32'h1);
        checkOutput("t5_post_drop", 32'(bus.drop_cnt), 32'h1);
        checkOutput("t5_post_ovf", 32'(bus.overflow), 32'h1);
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        bus.out_ready = 1'b0;
        checkOutput("t5_drained", 32'(bus.fifo_count), 32'h0);

        $display("[TB] timestamp");
        applyStimulus(1'b1, 32'h61, 2'b00, 2'b00);
        cycle();
        bus.done_in = 1'b0;
        repeat (6) cycle();
        applyStimulus(1'b1, 32'h62, 2'b00, 2'b00);
        cycle();
        bus.done_in = 1'b0;
        t1 = bus.out_tstamp;
        checkOutput("t6_first_data", bus.out_data, 32'h61);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        t2 = bus.out_tstamp;
        checkOutput("t6_second_data", bus.out_data, 32'h62);
`ifdef ECC_COLLECT_TIMESTAMP_EN
        checkOutput("t6_tstamp_diff", 32'(16'(t2 - t1)), 32'd7);
`else
        checkOutput("t6_tstamp_first", 32'(t1), 32'h0);
        checkOutput("t6_tstamp_second", 32'(t2), 32'h0);
`endif
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        checkOutput("t6_empty", 32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/ecc_result_collector.md
Name: ecc_result_collector

Overview:
- Downstream stage of the APB-controlled ECC encoder/decoder top.
- Watches the top's operation_done, data_out and num_of_errors outputs, and captures each completed operation into a small FIFO.
- Presents captured results on a valid/ready stream and keeps saturating error-statistics counters for the host.

Parameters:
DATA_WIDTH, 32, width of captured data_out word
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_WIDTH, 16, width of each statistics counter

Ports:
clk  input  1  clock
rst  input  1  reset
done_in  input  1  operation_done from ECC top
data_in  input  DATA_WIDTH  data_out from ECC top
nerr_in  input  2  num_of_errors from ECC top
mode_in  input  2  CTRL[1:0] in effect for the operation (00 enc, 01 dec, 10 full channel)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  DATA_WIDTH  head data
out_nerr  output  2  head error count
out_mode  output  2  head mode tag
out_tstamp  output  16  head timestamp (optional feature)
fifo_count  output  log2(DEPTH)+1  entries held
clear_stats  input  1  synchronous clear of counters and overflow flag
ops_cnt  output  CNT_WIDTH  operations captured or dropped
corr_cnt  output  CNT_WIDTH  operations with nerr_in==01
uncorr_cnt  output  CNT_WIDTH  operations with nerr_in>=10
drop_cnt  output  CNT_WIDTH  operations lost to full FIFO
overflow  output  1  sticky, set on any drop

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. On reset, all outputs go to 0 and the FIFO is empty. The done_in edge register resets to 0, so a done_in held high through reset release captures once.
- Capture event: rising edge of done_in, i.e. done_in=1 and the registered done_in of the previous cycle was 0. A done_in level held N cycles produces exactly one event.
  - data_in, nerr_in and mode_in are sampled in the same cycle as the edge.
- Latency: event sampled at edge N; entry written at edge N. If the FIFO was empty, out_valid=1 from cycle N+1 with the head fields valid.
- Pop: out_valid & out_ready at a clock edge removes the head. Head outputs are registered from the storage array and stay stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_data/out_nerr/out_mode/out_tstamp hold their last value (0 after reset).
- FIFO: circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits that wrap modulo DEPTH. fifo_count is updated the same edge as push/pop.
- Full (fifo_count==DEPTH) with an event and no pop in that cycle: the event is dropped, drop_cnt increments and overflow is set. Storage is unchanged.
- Full with an event and a pop in the same cycle: the push is accepted, fifo_count stays DEPTH, no drop.
- Empty with an event and out_ready=1: no bypass. The entry is written and popped no earlier than cycle N+1.
- Statistics: every event (accepted or dropped) increments ops_cnt. nerr_in==01 increments corr_cnt. nerr_in==10 or 11 increments uncorr_cnt. nerr_in==00 touches only ops_cnt.
  - All counters saturate at all-ones; no wrap.
- clear_stats=1: all counters and overflow go to 0 at the next edge. Clear has priority over a same-cycle increment, and that event's statistics are lost.
  - The FIFO contents are not affected by clear_stats.
- mode_in is a tag only; it does not affect counting.

Optional Feature:
- Macro ECC_COLLECT_TIMESTAMP_EN.
- Defined: a free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0) is stored with each entry. out_tstamp carries the counter value in the capture cycle of the head entry.
- Undefined: no counter or storage is built, and out_tstamp is tied to 0. The port always exists.

Test Plan:
1. Reset release, then done_in pulse 1 cycle with data_in=0x0000_00A5, nerr_in=00, mode_in=00 -> out_valid=1 next cycle, out_data=0xA5, ops_cnt=1, corr_cnt=0.
2. done_in held high 5 cycles, nerr_in=01 -> exactly one entry, corr_cnt=1, fifo_count=1.
3. out_ready=0, 5 events with data 1..5, DEPTH=4 -> fifo_count=4, drop_cnt=1, overflow=1, ops_cnt=5. Then out_ready=1 pops 1,2,3,4 in order, with out_valid low after the 4th.
4. FIFO full, event coincident with pop -> no drop, fifo_count stays 4, new data at tail.
5. uncorr_cnt preset near saturation by 2^16 events with nerr_in=10 -> holds 0xFFFF. Then clear_stats coincident with an event -> all counters 0, overflow 0, FIFO unchanged.
6. With ECC_COLLECT_TIMESTAMP_EN, two events 7 cycles apart -> out_tstamp difference 7; without the macro, out_tstamp=0.
